// File: rtl/aes_pkg.sv
// Shared AES key-schedule helpers: size functions, xtime, FSM state type.
package aes_pkg;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_t;

    function automatic int nk(input int key_size);
        return key_size / 32;
    endfunction

    function automatic int nr(input int key_size);
        return key_size / 32 + 6;
    endfunction

    function automatic int n_words(input int key_size);
        return (key_size / 32 + 7) * 4;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte, table lookup.
module aes_sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_s
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    assign o_s = SBOX[i_a];

endmodule

// File: rtl/aes_subword.sv
// SubWord: four parallel S-boxes over a 32-bit word, purely combinational.
module aes_subword (
    input  logic [31:0] i_w,
    output logic [31:0] o_w
);

    for (genvar g = 0; g < 4; g++) begin : g_sb
        aes_sbox u_sbox (
            .i_a (i_w[8*g +: 8]),
            .o_s (o_w[8*g +: 8])
        );
    end

endmodule

// File: rtl/key_sched_dec_stream.sv
// Iterative AES key expansion (one word per cycle) streaming round keys
// in decryption order, last round first, over valid/ready.
module key_sched_dec_stream
    import aes_pkg::*;
#(
    parameter int KEY_SIZE = 128,
    parameter int ROUNDS   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [KEY_SIZE-1:0] key,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [127:0]        rk,
    output logic [3:0]          rk_idx,
    output logic                rk_last
);

    localparam int NK      = nk(KEY_SIZE);
    localparam int N_WORDS = (ROUNDS + 1) * 4;
    localparam int IW      = $clog2(N_WORDS);
    localparam int CW      = $clog2(NK);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_i;
    logic [CW-1:0]   r_col;
    logic [7:0]      r_rcon;
    logic [3:0]      r_rnd;
    logic [31:0]     r_w [N_WORDS];

    logic [31:0]     w_prev;
    logic [31:0]     w_back;
    logic [31:0]     w_sub_in;
    logic [31:0]     w_sub_out;
    logic [31:0]     w_t;
    logic [31:0]     w_new;
    logic            w_accept;
    logic            w_expand;
    logic            w_last_word;
    logic            w_hs;
    logic [IW-1:0]   w_base;

    assign w_accept    = key_valid && (r_state == IDLE);
    assign w_expand    = (r_state == EXPAND);
    assign w_last_word = (r_i == IW'(N_WORDS - 1));
    assign w_hs        = rk_valid && rk_ready;

    assign w_prev = r_w[r_i - IW'(1)];
    assign w_back = r_w[r_i - IW'(NK)];

    // One S-box group serves both the RotWord column and the 256-bit mid column
    assign w_sub_in = (r_col == '0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_subword u_subword (
        .i_w (w_sub_in),
        .o_w (w_sub_out)
    );

    always_comb begin
        w_t = w_prev;
        if (r_col == '0) begin
            w_t = w_sub_out ^ {r_rcon, 24'h0};
        end else if (NK == 8 && int'(r_col) == 4) begin
            w_t = w_sub_out;
        end
    end

    assign w_new = w_back ^ w_t;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (key_valid) w_state_nxt = EXPAND;
            EXPAND:  if (w_last_word) w_state_nxt = STREAM;
            STREAM:  if (rk_ready && r_rnd == '0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i    <= '0;
            r_col  <= '0;
            r_rcon <= RCON_INIT;
            r_rnd  <= '0;
        end else if (w_accept) begin
            r_i    <= IW'(NK);
            r_col  <= '0;
            r_rcon <= RCON_INIT;
        end else if (w_expand) begin
            r_i   <= r_i + IW'(1);
            r_col <= (r_col == CW'(NK - 1)) ? '0 : r_col + CW'(1);
            if (r_col == '0) begin
                r_rcon <= xtime(r_rcon);
            end
            if (w_last_word) begin
                r_rnd <= 4'(ROUNDS);
            end
        end else if (w_hs && r_rnd != '0) begin
            r_rnd <= r_rnd - 4'd1;
        end
    end

    // Word store holds no reset; it is fully rewritten before every stream
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < NK; k++) begin
                r_w[k] <= key[KEY_SIZE-1-32*k -: 32];
            end
        end else if (w_expand) begin
            r_w[r_i] <= w_new;
        end
    end

    assign key_ready = (r_state == IDLE);
    assign rk_valid  = (r_state == STREAM);
    assign w_base    = IW'({r_rnd, 2'b00});

    assign rk      = rk_valid ? {r_w[w_base],
                                 r_w[w_base + IW'(1)],
                                 r_w[w_base + IW'(2)],
                                 r_w[w_base + IW'(3)]} : '0;
    assign rk_idx  = rk_valid ? r_rnd : 4'd0;
    assign rk_last = rk_valid && (r_rnd == 4'd0);

endmodule
